// File: rtl/button_io_responder_if.sv
// CPU data-bus slice seen by the push-button responder.
// The CPU drives the master side and the responder sits on the slave side.
interface button_io_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  wrEn;
  logic                  rdEn;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdHit;

  modport master (
    output addr, wrData, wrEn, rdEn,
    input  rdData, rdHit
  );

  modport slave (
    input  addr, wrData, wrEn, rdEn,
    output rdData, rdHit
  );
endinterface

// File: rtl/button_io_responder.sv
// Memory-mapped push-button responder on the CPU data bus.
// The block decodes a four-word window:
//   0x0 LEVEL  debounced levels {D,U,C}
//   0x4 PRESS  sticky press flags, cleared by reading them
//   0x8 COUNT  8-bit press counters, C in [7:0], U in [15:8], D in [23:16]
//   0xC CTRL   bit0 = capture enable; writing bit1 = 1 clears all counters and flags
// Each raw button passes through a 2-flop synchroniser and then a counting debouncer.
// Read data is registered and appears one cycle after rdEn.
module button_io_responder #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0100,
  parameter logic [19:0]           DEBOUNCE_CYC = 20'd50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btnC,
  input  logic                  btnU,
  input  logic                  btnD,
  button_io_responder_if.slave  bus
);

  // Debounce counter just wide enough to reach DEBOUNCE_CYC-1.
  localparam int unsigned   CNT_W    = (DEBOUNCE_CYC > 20'd2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 20'd1);

  localparam logic [1:0] OFF_LEVEL = 2'd0;
  localparam logic [1:0] OFF_PRESS = 2'd1;
  localparam logic [1:0] OFF_COUNT = 2'd2;
  localparam logic [1:0] OFF_CTRL  = 2'd3;

  // Button vector order matches the register bit order {D,U,C}.
  logic [2:0] btn_raw;
  assign btn_raw = {btnD, btnU, btnC};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       hit;
  logic [1:0] offset;
  logic       rd_hit;
  logic       rd_press;
  logic       wr_ctrl;
  logic       clr_all;

  assign hit      = (bus.addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign offset   = bus.addr[3:2];
  assign rd_hit   = bus.rdEn & hit;
  assign rd_press = rd_hit & (offset == OFF_PRESS);
  assign wr_ctrl  = bus.wrEn & hit & (offset == OFF_CTRL);
  assign clr_all  = wr_ctrl & bus.wrData[1];

  // Byte-lane bits and unused write-data bits carry no meaning for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[1:0], bus.wrData[DATA_WIDTH-1:2]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       stable_q, stable_d;
  logic [CNT_W-1:0] deb_q [3];
  logic [CNT_W-1:0] deb_d [3];
  logic [2:0]       flag_q, flag_d;
  logic [7:0]       cnt_q [3];
  logic [7:0]       cnt_d [3];
  logic             en_q, en_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_hit_q, rd_hit_d;

  logic [2:0]       rise;
  logic [2:0]       evt;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: a new level must persist DEBOUNCE_CYC cycles before it is accepted;
  // any return to the stable level restarts the count, so short glitches never pass.
  always_comb begin
    stable_d = stable_q;
    deb_d    = deb_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DEB_LAST) begin
        stable_d[i] = sync2_q[i];
        deb_d[i]    = '0;
      end else begin
        deb_d[i] = deb_q[i] + 1'b1;
      end
    end
  end

  // A press is the debounced 0->1 transition, taken in the same cycle the level commits.
  assign rise = stable_d & ~stable_q;
  assign evt  = rise & {3{en_q}};

  // Flags, counters and enable: a counter clear beats a new event, while a new event
  // beats the read-clear of PRESS so a press arriving during the read is never lost.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    if (wr_ctrl) begin
      en_d = bus.wrData[0];
    end
    if (clr_all) begin
      flag_d = 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_d[i] = 8'd0;
      end
    end else begin
      if (rd_press) begin
        flag_d = evt;
      end else begin
        flag_d = flag_q | evt;
      end
      for (int i = 0; i < 3; i++) begin
        cnt_d[i] = cnt_q[i] + {7'd0, evt[i]};
      end
    end
  end

  // Read mux: a hit returns the selected register as it stood before this cycle's write;
  // a miss or an idle cycle returns zero so the top-level mux can OR or select freely.
  always_comb begin
    rd_data_d = '0;
    rd_hit_d  = rd_hit;
    if (rd_hit) begin
      case (offset)
        OFF_LEVEL: rd_data_d = DATA_WIDTH'(stable_q);
        OFF_PRESS: rd_data_d = DATA_WIDTH'(flag_q);
        OFF_COUNT: rd_data_d = DATA_WIDTH'({cnt_q[2], cnt_q[1], cnt_q[0]});
        OFF_CTRL:  rd_data_d = DATA_WIDTH'(en_q);
        default:   rd_data_d = '0;
      endcase
    end
  end

  // State register for debouncers, flags, counters, enable and read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q  <= 3'b000;
      flag_q    <= 3'b000;
      en_q      <= 1'b1;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        deb_q[i] <= '0;
        cnt_q[i] <= 8'd0;
      end
    end else begin
      stable_q  <= stable_d;
      flag_q    <= flag_d;
      en_q      <= en_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
      for (int i = 0; i < 3; i++) begin
        deb_q[i] <= deb_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.rdData = rd_data_q;
  assign bus.rdHit  = rd_hit_q;

endmodule

// File: tb/tb_button_io_responder.sv
// Directed testbench for button_io_responder with DEBOUNCE_CYC = 4.
module tb_button_io_responder;

  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam logic [31:0] A_LEVEL = BASE + 32'h0;
  localparam logic [31:0] A_PRESS = BASE + 32'h4;
  localparam logic [31:0] A_COUNT = BASE + 32'h8;
  localparam logic [31:0] A_CTRL  = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst;
  logic btnC, btnU, btnD;

  int checks = 0;
  int errors = 0;

  button_io_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  button_io_responder #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .DEBOUNCE_CYC(20'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btnC(btnC),
    .btnU(btnU),
    .btnD(btnD),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // All helpers start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.addr = a;
    bus.rdEn = 1'b1;
    @(posedge clk);
    #1;
    d = bus.rdData;
    h = bus.rdHit;
    bus.rdEn = 1'b0;
    bus.addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
    bus.addr   = a;
    bus.wrData = w;
    bus.wrEn   = 1'b1;
    @(posedge clk);
    #1;
    bus.wrEn   = 1'b0;
    bus.wrData = '0;
    bus.addr   = '0;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btnC = v;
      1: btnU = v;
      default: btnD = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(8);
    set_btn(b, 1'b0);
    tick(8);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic h;
    rst = 1'b0;
    btnC = 1'b0; btnU = 1'b0; btnD = 1'b0;
    bus.addr = '0; bus.wrData = '0; bus.wrEn = 1'b0; bus.rdEn = 1'b0;
    tick(3);
    checks++;
    if (bus.rdData !== 32'h0 || bus.rdHit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdData=%h rdHit=%b expected 00000000/0", bus.rdData, bus.rdHit);
    end
    rst = 1'b1;
    tick(2);
    bus_read(A_CTRL, d, h);
    checks++;
    if (d !== 32'h1 || h !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: rdData=%h rdHit=%b expected 00000001/1", d, h);
    end
    bus_read(A_LEVEL, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      errors++;
      $display("FAIL reset_level: rdData=%h rdHit=%b expected 00000000/1", d, h);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_press: rdData=%h expected 00000000", d);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_count: rdData=%h expected 00000000", d);
    end
  endtask

  task automatic test_level_timing();
    logic [31:0] d;
    logic h;
    // Button rises just after edge E0; the level commits at E6.
    btnU = 1'b1;
    tick(4);
    bus_read(A_LEVEL, d, h);   // sampled at E5
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL level_early: rdData=%h expected 00000000", d);
    end
    tick(1);
    bus_read(A_LEVEL, d, h);   // sampled at E7
    checks++;
    if (d !== 32'h2 || h !== 1'b1) begin
      errors++;
      $display("FAIL level_u: rdData=%h rdHit=%b expected 00000002/1", d, h);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL press_u: rdData=%h expected 00000002", d);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0000_0100) begin
      errors++;
      $display("FAIL count_u: rdData=%h expected 00000100", d);
    end
    btnU = 1'b0;
    tick(8);
    bus_read(A_LEVEL, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL level_u_release: rdData=%h expected 00000000", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic h;
    btnC = 1'b1;
    tick(3);
    btnC = 1'b0;
    tick(10);
    bus_read(A_LEVEL, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_level: rdData=%h expected 00000000", d);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_press: rdData=%h expected 00000000", d);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0000_0100) begin
      errors++;
      $display("FAIL glitch_count: rdData=%h expected 00000100", d);
    end
  endtask

  task automatic test_press_read_clear();
    logic [31:0] d;
    logic h;
    press(2);
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h4 || h !== 1'b1) begin
      errors++;
      $display("FAIL press_d_first: rdData=%h rdHit=%b expected 00000004/1", d, h);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      errors++;
      $display("FAIL press_d_second: rdData=%h rdHit=%b expected 00000000/1", d, h);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0001_0100) begin
      errors++;
      $display("FAIL count_d: rdData=%h expected 00010100", d);
    end
  endtask

  task automatic test_wrap_and_clear();
    logic [31:0] d;
    logic h;
    for (int n = 0; n < 256; n++) begin
      press(0);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0001_0100) begin
      errors++;
      $display("FAIL count_wrap: rdData=%h expected 00010100", d);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL press_wrap: rdData=%h expected 00000001", d);
    end
    press(1);
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0001_0200) begin
      errors++;
      $display("FAIL count_before_clear: rdData=%h expected 00010200", d);
    end
    bus_write(A_CTRL, 32'h3);
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL count_cleared: rdData=%h expected 00000000", d);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL press_cleared: rdData=%h expected 00000000", d);
    end
    bus_read(A_CTRL, d, h);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_after_clear: rdData=%h expected 00000001", d);
    end
  endtask

  task automatic test_enable_off();
    logic [31:0] d;
    logic h;
    bus_write(A_CTRL, 32'h0);
    bus_read(A_CTRL, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_disabled: rdData=%h expected 00000000", d);
    end
    btnU = 1'b1;
    tick(8);
    bus_read(A_LEVEL, d, h);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL level_disabled: rdData=%h expected 00000002", d);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL press_disabled: rdData=%h expected 00000000", d);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL count_disabled: rdData=%h expected 00000000", d);
    end
    btnU = 1'b0;
    tick(8);
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic h;
    press(0);
    bus_write(A_COUNT, 32'h2);
    bus_write(A_LEVEL, 32'h0);
    bus_write(BASE + 32'h1C, 32'h2);
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL count_after_ignored_writes: rdData=%h expected 00000001", d);
    end
    bus_read(A_CTRL, d, h);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_after_ignored_writes: rdData=%h expected 00000001", d);
    end
    bus_read(BASE + 32'h10, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b0) begin
      errors++;
      $display("FAIL read_miss: rdData=%h rdHit=%b expected 00000000/0", d, h);
    end
    bus_read(BASE + 32'hF, d, h);
    checks++;
    if (d !== 32'h1 || h !== 1'b1) begin
      errors++;
      $display("FAIL read_byte_offset: rdData=%h rdHit=%b expected 00000001/1", d, h);
    end
  endtask

  task automatic test_back_to_back();
    bus.rdEn = 1'b1;
    bus.addr = A_LEVEL;
    tick(1);
    checks++;
    if (bus.rdData !== 32'h0 || bus.rdHit !== 1'b1) begin
      errors++;
      $display("FAIL b2b_level: rdData=%h rdHit=%b expected 00000000/1", bus.rdData, bus.rdHit);
    end
    bus.addr = A_COUNT;
    tick(1);
    checks++;
    if (bus.rdData !== 32'h1 || bus.rdHit !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: rdData=%h rdHit=%b expected 00000001/1", bus.rdData, bus.rdHit);
    end
    bus.addr = 32'h0000_0000;
    tick(1);
    checks++;
    if (bus.rdData !== 32'h0 || bus.rdHit !== 1'b0) begin
      errors++;
      $display("FAIL b2b_miss: rdData=%h rdHit=%b expected 00000000/0", bus.rdData, bus.rdHit);
    end
    bus.addr = A_CTRL;
    tick(1);
    checks++;
    if (bus.rdData !== 32'h1 || bus.rdHit !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ctrl: rdData=%h rdHit=%b expected 00000001/1", bus.rdData, bus.rdHit);
    end
    bus.rdEn = 1'b0;
    tick(1);
    checks++;
    if (bus.rdData !== 32'h0 || bus.rdHit !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: rdData=%h rdHit=%b expected 00000000/0", bus.rdData, bus.rdHit);
    end
    bus.addr = '0;
  endtask

  task automatic test_read_write_same_cycle();
    logic [31:0] d;
    logic h;
    bus.addr   = A_CTRL;
    bus.wrData = 32'h0;
    bus.wrEn   = 1'b1;
    bus.rdEn   = 1'b1;
    tick(1);
    d = bus.rdData;
    bus.wrEn = 1'b0;
    bus.rdEn = 1'b0;
    bus.addr = '0;
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL rdwr_old_value: rdData=%h expected 00000001", d);
    end
    bus_read(A_CTRL, d, h);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rdwr_new_value: rdData=%h expected 00000000", d);
    end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic h;
    btnD = 1'b1;
    tick(3);
    bus_read(A_CTRL, d, h);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL mid_rdhit_before_reset: rdHit=%b expected 1", h);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rdData !== 32'h0 || bus.rdHit !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: rdData=%h rdHit=%b expected 00000000/0", bus.rdData, bus.rdHit);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_read(A_CTRL, d, h);
    checks++;
    if (d !== 32'h1 || h !== 1'b1) begin
      errors++;
      $display("FAIL mid_ctrl_after_reset: rdData=%h rdHit=%b expected 00000001/1", d, h);
    end
    tick(8);
    bus_read(A_LEVEL, d, h);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL held_level: rdData=%h expected 00000004", d);
    end
    bus_read(A_COUNT, d, h);
    checks++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL held_count: rdData=%h expected 00010000", d);
    end
    bus_read(A_PRESS, d, h);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL held_press: rdData=%h expected 00000004", d);
    end
    btnD = 1'b0;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_level_timing();
    test_glitch();
    test_press_read_clear();
    test_wrap_and_clear();
    test_enable_off();
    test_window();
    test_back_to_back();
    test_read_write_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
